// File: rtl/tft_pixel_fifo.sv
// tft_pixel_fifo: pixel FIFO between producer and TFT timing stage, frame-aligned to vsync.
// Optional underflow counter enabled by defining TFT_PIXEL_FIFO_UFCNT_EN.
module tft_pixel_fifo #(
    parameter int          DEPTH      = 1024,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [23:0]              i_data,
    input  logic                     i_sof,
    output logic                     o_ready,
    input  logic                     i_de,
    input  logic                     i_vsync,
    output logic [23:0]              o_pixel,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_underflow,
    output logic [15:0]              o_uf_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state, nxt;
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          vs_q, vs_edge, full, empty, wr, pop, uf;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign vs_edge = i_vsync && !vs_q;
    assign o_level = cnt;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= nxt;

    // Next state: SOF starts a fill, vsync starts streaming, underflow flushes
    always_comb
        case (state)
            IDLE:    nxt = (wr && i_sof) ? FILL : IDLE;
            FILL:    nxt = vs_edge ? RUN : FILL;
            RUN:     nxt = uf ? FLUSH : RUN;
            default: nxt = IDLE;
        endcase

    // Handshake and FIFO strobes; ready is held low while reset is asserted
    always_comb begin
        o_ready = i_rst_n && !full && state != FLUSH;
        wr      = i_valid && o_ready && (state != IDLE || i_sof);
        pop     = state == RUN && i_de && !empty;
        uf      = state == RUN && i_de && empty;
    end

    // Pointers, occupancy and vsync history; FLUSH discards everything buffered
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            vs_q <= 1'b0;
        end else begin
            vs_q <= i_vsync;
            if (state == FLUSH) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= wp + AW'(wr);
                rp  <= rp + AW'(pop);
                cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
            end
        end

    // Pixel storage, no reset needed
    always_ff @(posedge i_clk)
        if (wr) mem[wp] <= i_data;

    // Registered pixel output and underflow pulse
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            o_pixel     <= FILL_COLOR;
            o_underflow <= 1'b0;
        end else begin
            o_underflow <= uf;
            o_pixel     <= pop ? mem[rp] : (uf || state != RUN) ? FILL_COLOR : o_pixel;
        end

`ifdef TFT_PIXEL_FIFO_UFCNT_EN
    // Saturating underflow counter, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)                     o_uf_count <= '0;
        else if (uf && o_uf_count != '1) o_uf_count <= o_uf_count + 16'd1;
`else
    assign o_uf_count = '0;
`endif

endmodule

// File: doc/tft_pixel_fifo.md
# tft_pixel_fifo

Pixel-stream buffer that sits directly upstream of the TFT LCD timing generator. It accepts 24-bit pixels from a producer with a valid/ready handshake and frame-start marker, stores them in a FIFO, and presents one pixel per data-enable cycle to the timing stage. It also aligns the producer's frame to the panel's vertical sync and recovers cleanly from underflow.

## Interface
- DEPTH, 1024, FIFO depth in pixels; power of two, minimum 4
- FILL_COLOR, 24'h000000, pixel driven while not streaming or on underflow
- i_clk  in  1  pixel clock, same clock as the timing generator
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  producer word valid
- i_data  in  24  producer pixel, {B[23:16], G[15:8], R[7:0]}
- i_sof  in  1  qualifies i_data as first pixel of a frame
- o_ready  out  1  FIFO can accept a word this cycle
- i_de  in  1  timing-stage data enable; one pop request per high cycle
- i_vsync  in  1  timing-stage vertical sync
- o_pixel  out  24  pixel to the timing stage
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- o_underflow  out  1  one-cycle pulse on underflow
- o_uf_count  out  16  underflow counter (see Configuration)

## Operation
- Reset values: o_ready=0, o_pixel=FILL_COLOR, o_level=0, o_underflow=0, o_uf_count=0, state IDLE. Pointers are cleared; no storage reset is required.
- Write: occurs when i_valid && o_ready. o_ready = !full && state!=FLUSH, evaluated from the registered count. Full with a simultaneous pop gives o_ready=0 that cycle.
- Pop: occurs when state==RUN && i_de && !empty.
- vsync edge: detected as i_vsync registered low previously and high now.
- IDLE:
  - o_ready follows !full.
  - Words with i_sof=0 are accepted but discarded.
  - A word with i_sof=1 is written and moves the block to FILL.
- FILL:
  - Accepted words are written; no pops occur.
  - On a vsync edge, go to RUN. The edge seen in the same cycle as the IDLE→FILL transition does not count.
- RUN:
  - Writes and pops proceed concurrently. A simultaneous write and pop leaves o_level unchanged.
  - If i_de=1 while empty, that is an underflow. A same-cycle write does not bypass the FIFO. On underflow: o_pixel=FILL_COLOR, o_underflow pulses, go to FLUSH.
  - A word with i_sof=1 arriving in RUN is written normally. The SOF flag is not stored.
- FLUSH: lasts one cycle. Pointers and count are cleared, o_ready=0, and the next state is IDLE.
- o_pixel:
  - Registered.
  - On a pop, it takes the FIFO head.
  - On an underflow, or when state is not RUN, it takes FILL_COLOR.
  - Otherwise it holds its value.
- Pointers are $clog2(DEPTH) bits and wrap naturally. The count is one bit wider so that full = (count==DEPTH).
- Asserting reset mid-frame clears the block immediately. After release, operation restarts in IDLE and waits for a new SOF.

## Timing
- Pop latency is 1 cycle: the pixel is valid on o_pixel in the cycle after the i_de cycle that popped it. The timing generator samples it in that following cycle.
- Write-to-pop minimum latency is 2 cycles. A word written at cycle N is visible to a pop at N+1, and appears on o_pixel at N+2.
- o_level updates the cycle after the write or pop.
- o_underflow is high for exactly the cycle after the offending i_de.
- The FILL→RUN transition happens the cycle after the vsync edge. The first pop is possible in that RUN cycle.

## Configuration
- TFT_PIXEL_FIFO_UFCNT_EN defined:
  - o_uf_count increments by 1 on each underflow and saturates at 16'hFFFF.
  - It is cleared only by reset.
- Not defined: o_uf_count is tied to 0 and no counter logic is synthesized. o_underflow is unaffected.

## Test plan
- Reset mid-RUN with o_level=10: assert i_rst_n=0 → immediately o_level=0, o_ready=0, o_pixel=24'h000000. After release, state is IDLE.
- Send 3 words with sof=0, then word 24'h112233 with sof=1, then 24'h445566. Pulse vsync, then hold i_de=1 for 2 cycles → o_pixel=24'h112233, then 24'h445566 on the following cycles. Discarded words never appear.
- DEPTH=4: write 4 words in FILL → o_ready=0 and o_level=4. Further i_valid is not accepted. In RUN, one pop brings o_ready back to 1 the next cycle.
- In RUN with o_level=1: apply i_de for 2 cycles → the first pixel is output, then o_pixel=FILL_COLOR and o_underflow pulses once. State goes through FLUSH to IDLE, with o_level=0.
- In RUN with a simultaneous write and pop at o_level=5 → o_level stays 5. Pixel order is preserved across pointer wrap after 3×DEPTH transfers.
- With TFT_PIXEL_FIFO_UFCNT_EN, force 3 underflows → o_uf_count=3. Without the macro, o_uf_count=0 throughout.
